// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Accepts SB/SH/SW stores from the MEM stage. Each store's data is replicated
// onto the 32-bit bus and given byte strobes. Accepted stores wait in a
// small in-order FIFO and drain to data memory over a valid/ready handshake.
// A load whose word address matches any pending store raises ld_hazard, so
// the hazard unit can stall that load until the store has drained.
//
// Handshakes (strict valid/ready):
//   Store side: a store is taken on a rising edge when st_valid is high,
//   st_type != 00, st_ready is high and the address is aligned for the
//   access size. st_ready depends only on the registered count.
//   Memory side: the head entry transfers on a rising edge when mem_wvalid
//   and mem_wready are both high. While mem_wvalid is high and mem_wready is
//   low, mem_waddr/mem_wdata/mem_wstrb are held stable.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   st_valid        store request this cycle
//   st_type         00 none, 01 SB, 10 SH, 11 SW
//   st_addr         byte address of the store
//   st_data         unaligned rs2 value
//   st_ready        room for one more entry (count < DEPTH)
//   ld_check_addr   byte address of the load currently in MEM
//   ld_hazard       a valid entry shares ld_check_addr's word address
//   mem_wvalid      head entry presented to memory
//   mem_waddr       word-aligned head address (0 when empty)
//   mem_wdata       aligned head data (0 when empty)
//   mem_wstrb       head byte enables, bit i covers wdata[8i+7:8i]
//   mem_wready      memory accepts the head entry
//   misalign        one-cycle pulse after a rejected misaligned store
//   count           number of valid entries
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [1:0]               st_type,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    output logic                     st_ready,
    input  logic [31:0]              ld_check_addr,
    output logic                     ld_hazard,
    output logic                     mem_wvalid,
    output logic [31:0]              mem_waddr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic                     mem_wready,
    output logic                     misalign,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    // -----------------------------------------------------------------------
    // Entry storage. Addresses are kept as word addresses only; the byte
    // offset is fully captured by the strobes.
    // -----------------------------------------------------------------------
    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       strb_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    // -----------------------------------------------------------------------
    // Store decode: alignment check and bus encoding
    // -----------------------------------------------------------------------
    logic        st_aligned;
    logic [31:0] enc_data;
    logic [3:0]  enc_strb;

    always_comb begin
        st_aligned = 1'b1;
        enc_data   = 32'h0;
        enc_strb   = 4'h0;
        case (st_type)
            ST_SB: begin
                enc_data = {4{st_data[7:0]}};
                enc_strb = 4'b0001 << st_addr[1:0];
            end
            ST_SH: begin
                st_aligned = ~st_addr[0];
                enc_data   = {2{st_data[15:0]}};
                enc_strb   = 4'b0011 << st_addr[1:0];
            end
            ST_SW: begin
                st_aligned = (st_addr[1:0] == 2'b00);
                enc_data   = st_data;
                enc_strb   = 4'b1111;
            end
            default: begin
                st_aligned = 1'b1;
                enc_data   = 32'h0;
                enc_strb   = 4'h0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Handshake qualification
    // -----------------------------------------------------------------------
    logic st_req;
    logic do_push;
    logic do_pop;
    logic bad_store;

    // st_ready is low at full even if the head drains this same cycle; there
    // is deliberately no pass-through so st_ready never sees mem_wready.
    assign st_ready   = (count_q != FULL_COUNT);
    assign mem_wvalid = (count_q != '0);

    assign st_req    = st_valid && (st_type != ST_NONE);
    assign do_push   = st_req && st_aligned && st_ready;
    assign bad_store = st_req && !st_aligned;
    assign do_pop    = mem_wvalid && mem_wready;

    // -----------------------------------------------------------------------
    // Control state: pointers, count, valid bits, misalign pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= bad_store;

            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            // A push and a pop never target the same slot: equal pointers
            // mean empty (no pop) or full (no push).
            for (int i = 0; i < DEPTH; i++) begin
                if (do_pop && (rd_ptr == PW'(i))) begin
                    valid_q[i] <= 1'b0;
                end
                if (do_push && (wr_ptr == PW'(i))) begin
                    valid_q[i] <= 1'b1;
                end
            end
        end
    end

    // Payload needs no reset: it is only observed through valid_q / count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_ptr] <= st_addr[31:2];
            data_q[wr_ptr] <= enc_data;
            strb_q[wr_ptr] <= enc_strb;
        end
    end

    // -----------------------------------------------------------------------
    // Head presentation, zeroed while empty
    // -----------------------------------------------------------------------
    always_comb begin
        mem_waddr = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        if (mem_wvalid) begin
            mem_waddr = {addr_q[rd_ptr], 2'b00};
            mem_wdata = data_q[rd_ptr];
            mem_wstrb = strb_q[rd_ptr];
        end
    end

    // -----------------------------------------------------------------------
    // Load hazard: only registered valid entries are compared, so a store
    // being pushed this cycle is ignored and one being popped still counts.
    // -----------------------------------------------------------------------
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == ld_check_addr[31:2])) begin
                ld_hazard = 1'b1;
            end
        end
    end

    // The load's byte offset is irrelevant to a word-granular hazard.
    logic unused_ld_offset;
    assign unused_ld_offset = ^ld_check_addr[1:0];

    assign count = count_q;

endmodule
